// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: FSM state encoding,
// frame geometry and the default baud divider for a 50 MHz clock.
package uart_pkg;

    localparam int DATA_BITS            = 8;
    localparam int CLK_HZ               = 50_000_000;
    localparam int BAUD_115200          = 115_200;
    // 50 MHz / 115200 = 434.03, truncated; the small rate error is tolerated by receivers
    localparam int CLKS_PER_BIT_DEFAULT = CLK_HZ / BAUD_115200;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Total clk cycles from acceptance to the end of the last stop bit
    function automatic int frame_cycles(input int cpb, input int stop_bits, input bit parity);
        return (10 + stop_bits - 1) * cpb + (parity ? cpb : 0);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and strobes bit_done on the
// last count. clr restarts the period (driven by the FSM on state change).
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic bit_done
);

    localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign bit_done = (cnt == LAST);

    // Free-running period counter, reloaded at the end of each bit or on clear
    always_ff @(posedge clk) begin
        if (rst || clr || bit_done) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial UART transmitter, 8N1 / 8N2 by default.
// Optional even parity bit between data and stop: define UART_TX_PARITY_EN
// for 8E1 / 8E2 framing.
// A new byte is taken in IDLE or in the final cycle of the last stop bit,
// so a continuously valid source streams frames with no idle gap.
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       byte_ready,
    output logic       busy,
    output logic       tx
);

    localparam logic [2:0] LAST_DATA = 3'(DATA_BITS - 1);
    localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

    uart_state_e          state_q, state_nxt;
    logic [DATA_BITS-1:0] sh_q, sh_nxt;
    logic [2:0]           bit_cnt_q, bit_cnt_nxt;
    logic                 tx_q, tx_nxt;
    logic                 busy_q, busy_nxt;
    logic                 br_q;
    logic                 accept;
    logic                 bit_done;
    logic                 baud_clr;

`ifdef UART_TX_PARITY_EN
    logic                 par_q;
`endif

    // The period restarts whenever the FSM moves, and is held at zero while idle
    assign baud_clr = (state_nxt != state_q) || (state_q == IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst      (rst),
        .clr      (baud_clr),
        .bit_done (bit_done)
    );

    // Next-state, next-line-level and acceptance decode
    always_comb begin
        state_nxt   = state_q;
        sh_nxt      = sh_q;
        bit_cnt_nxt = bit_cnt_q;
        tx_nxt      = tx_q;
        busy_nxt    = busy_q;
        accept      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_nxt   = 1'b1;
                busy_nxt = 1'b0;
                accept   = valid;
            end
            START: begin
                if (bit_done) begin
                    state_nxt   = DATA;
                    bit_cnt_nxt = '0;
                    tx_nxt      = sh_q[0];
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_cnt_q == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt = PARITY;
                        tx_nxt    = par_q;
`else
                        state_nxt = STOP;
                        tx_nxt    = 1'b1;
`endif
                        bit_cnt_nxt = '0;
                    end else begin
                        sh_nxt      = {1'b0, sh_q[DATA_BITS-1:1]};
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                        tx_nxt      = sh_nxt[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_done) begin
                    state_nxt   = STOP;
                    bit_cnt_nxt = '0;
                    tx_nxt      = 1'b1;
                end
            end
`endif
            STOP: begin
                tx_nxt = 1'b1;
                if (bit_done) begin
                    if (bit_cnt_q == LAST_STOP) begin
                        // Last stop cycle: chain straight into the next frame if one waits
                        if (valid) begin
                            accept = 1'b1;
                        end else begin
                            state_nxt = IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                tx_nxt    = 1'b1;
                busy_nxt  = 1'b0;
            end
        endcase

        // Start bit goes out on the accepting edge itself
        if (accept) begin
            state_nxt   = START;
            sh_nxt      = data;
            bit_cnt_nxt = '0;
            tx_nxt      = 1'b0;
            busy_nxt    = 1'b1;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            sh_q      <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            br_q      <= 1'b0;
        end else begin
            state_q   <= state_nxt;
            sh_q      <= sh_nxt;
            bit_cnt_q <= bit_cnt_nxt;
            tx_q      <= tx_nxt;
            busy_q    <= busy_nxt;
            br_q      <= accept;
        end
    end

`ifdef UART_TX_PARITY_EN
    // Even parity is taken from the byte as accepted, before any shifting
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (accept) begin
            par_q <= ^data;
        end
    end
`endif

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign byte_ready = br_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: two instances (1 and 2 stop bits) at
// CLKS_PER_BIT=4 share stimulus. A frame-level reference model predicts the
// line waveform; directed tables and sequences cover the corner cases.
module tb_uart_tx_serializer;

    localparam int N = 4;
`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int L1 = (10 + (PAR ? 1 : 0)) * N;
    localparam int L2 = (11 + (PAR ? 1 : 0)) * N;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid = 1'b0;
    logic [7:0] data = 8'h00;
    logic [1:0] tx_w, busy_w, br_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLKS_PER_BIT(N), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .byte_ready(br_w[0]), .busy(busy_w[0]), .tx(tx_w[0])
    );

    uart_tx_serializer #(.CLKS_PER_BIT(N), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst(rst), .data(data), .valid(valid),
        .byte_ready(br_w[1]), .busy(busy_w[1]), .tx(tx_w[1])
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- reference model ----------------
    // Each accepted byte expands to a per-cycle waveform of its whole frame;
    // the line simply plays it back. A new byte is taken when nothing or only
    // the final cycle of the current frame is left.
    logic wave [2][0:63];
    int   len_m [2];
    int   pos_m [2];
    logic e_tx [2];
    logic e_busy [2];
    logic e_br [2];

    function automatic void build(input int i, input logic [7:0] d);
        logic seq [0:11];
        int   nb;
        seq[0] = 1'b0;
        for (int b = 0; b < 8; b++) seq[1 + b] = d[b];
        nb = 9;
        if (PAR) begin
            seq[9] = ^d;
            nb = 10;
        end
        for (int s = 0; s < i + 1; s++) begin
            seq[nb] = 1'b1;
            nb++;
        end
        for (int k = 0; k < nb * N; k++) wave[i][k] = seq[k / N];
        len_m[i] = nb * N;
    endfunction

    initial begin
        for (int i = 0; i < 2; i++) begin
            len_m[i] = 0; pos_m[i] = 0;
            e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_br[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                len_m[i] = 0;
                pos_m[i] = 0;
                e_br[i]  = 1'b0;
            end else if (valid && (pos_m[i] + 1 >= len_m[i])) begin
                build(i, data);
                pos_m[i] = 0;
                e_br[i]  = 1'b1;
            end else begin
                if (pos_m[i] < len_m[i]) pos_m[i]++;
                e_br[i] = 1'b0;
            end
            e_busy[i] = (pos_m[i] < len_m[i]);
            e_tx[i]   = e_busy[i] ? wave[i][pos_m[i]] : 1'b1;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("model_tx%0d", i),   32'(tx_w[i]),   32'(e_tx[i]));
            chk($sformatf("model_busy%0d", i), 32'(busy_w[i]), 32'(e_busy[i]));
            chk($sformatf("model_br%0d", i),   32'(br_w[i]),   32'(e_br[i]));
        end
    end

    // ---------------- directed helpers ----------------
    int bc0, bc1, brc1;

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
        if (busy_w[0]) bc0++;
        if (busy_w[1]) bc1++;
        if (br_w[1])   brc1++;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 400; k++) begin
            if (busy_w == 2'b00) break;
            cycle();
        end
        chk({nm, "_idle_timeout"}, 32'(busy_w), 32'd0);
    endtask

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       etx;
        logic       ebusy;
        logic       ebr;
    } vec_t;

    initial begin
        vec_t        tbl[$];
        vec_t        r;
        logic [11:0] b55;
        int          k;

        // Line levels of a 0x55 frame, one entry per bit period (start first)
        b55 = PAR ? 12'b1100_1010_1010 : 12'b1110_1010_1010;

        for (int c = 0; c < 20; c++) begin
            r.v = 1'b0; r.d = 8'h00; r.etx = 1'b1; r.ebusy = 1'b0; r.ebr = 1'b0;
            tbl.push_back(r);
        end
        for (int c = 0; c < L1; c++) begin
            r.v = (c == 0); r.d = 8'h55; r.etx = b55[c / N]; r.ebusy = 1'b1; r.ebr = (c == 0);
            tbl.push_back(r);
        end
        for (int c = 0; c < 3; c++) begin
            r.v = 1'b0; r.d = 8'h00; r.etx = 1'b1; r.ebusy = 1'b0; r.ebr = 1'b0;
            tbl.push_back(r);
        end

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_tx",   32'(tx_w),   32'h3);
        chk("reset_busy", 32'(busy_w), 32'h0);
        chk("reset_br",   32'(br_w),   32'h0);
        rst = 1'b0;

        // Idle period followed by a single 0x55 frame
        foreach (tbl[i]) begin
            valid = tbl[i].v;
            data  = tbl[i].d;
            cycle();
            chk($sformatf("tbl%0d_tx", i),   32'(tx_w[0]),   32'(tbl[i].etx));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_w[0]), 32'(tbl[i].ebusy));
            chk($sformatf("tbl%0d_br", i),   32'(br_w[0]),   32'(tbl[i].ebr));
        end
        wait_idle("tbl");

        // Back-to-back: valid held, byte swapped when byte_ready is seen
        valid = 1'b1; data = 8'h48;
        cycle();
        chk("b2b_br_first", 32'(br_w[0]), 32'd1);
        data = 8'h65;
        for (k = 1; k <= 200; k++) begin
            cycle();
            if (br_w[0]) break;
        end
        chk("b2b_second_br_cycle", 32'(k), 32'(L1));
        chk("b2b_no_gap_start", 32'(tx_w[0]), 32'd0);
        valid = 1'b0;
        wait_idle("b2b");

        // Reset during data bit 3 of 0xA3
        valid = 1'b1; data = 8'hA3;
        cycle();
        valid = 1'b0; data = 8'h00;
        repeat (4 * N + 1) cycle();
        chk("rst_pre_bit3", 32'(tx_w[0]), 32'd0);
        rst = 1'b1;
        cycle();
        chk("rst_mid_tx",   32'(tx_w),   32'h3);
        chk("rst_mid_busy", 32'(busy_w), 32'h0);
        rst = 1'b0;
        cycle();
        bc0 = 0;
        valid = 1'b1; data = 8'hC5;
        cycle();
        valid = 1'b0;
        wait_idle("rst_after");
        chk("rst_after_len", 32'(bc0), 32'(L1));

        // Parity bit position: 0x07 (odd count) then 0x03 (even count)
        for (int p = 0; p < 2; p++) begin
            logic [7:0] pd;
            logic       exp9;
            pd   = (p == 0) ? 8'h07 : 8'h03;
            exp9 = PAR ? ((p == 0) ? 1'b1 : 1'b0) : 1'b1;
            bc0 = 0;
            valid = 1'b1; data = pd;
            cycle();
            valid = 1'b0;
            repeat (9 * N + 1) cycle();
            chk($sformatf("par_bit9_%02h", pd), 32'(tx_w[0]), 32'(exp9));
            wait_idle("par");
            chk($sformatf("par_len_%02h", pd), 32'(bc0), 32'(L1));
        end

        // Two stop bits: valid pulse during the first stop bit is ignored
        bc0 = 0; bc1 = 0;
        valid = 1'b1; data = 8'hFF;
        cycle();
        valid = 1'b0;
        brc1 = 0;
        repeat ((9 + (PAR ? 1 : 0)) * N) cycle();
        chk("stop2_in_stop", 32'(tx_w[1]), 32'd1);
        valid = 1'b1; data = 8'h12;
        cycle();
        valid = 1'b0;
        chk("stop2_ignored_br", 32'(br_w), 32'h0);
        wait_idle("stop2");
        chk("stop2_len1", 32'(bc0), 32'(L1));
        chk("stop2_len2", 32'(bc1), 32'(L2));
        chk("stop2_no_br", 32'(brc1), 32'd0);

        // Randomized traffic, occasional reset, checked by the model
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 399) == 0);
            valid = ($urandom_range(0, 3) == 0);
            data  = 8'($urandom);
            cycle();
        end
        rst = 1'b0; valid = 1'b0;
        wait_idle("rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
